// File: rtl/fpu_issue.sv
// fpu_issue: issue stage wrapped around a fixed-latency FPU.
//
// The block queues commands in a command FIFO and issues them to the FPU
// operand registers one per cycle. It follows each issued operation through a
// LATENCY-deep valid/opcode pipe and captures the FPU result into a result
// FIFO on the edge where the tracked entry leaves the pipe. Issue is gated by
// a credit count of in-flight plus buffered results, so a capture can never
// overflow the result FIFO.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              command handshake
//   in_a, in_b, in_op              command payload
//   fpu_a, fpu_b, fpu_opcode       registered operands to the FPU
//   fpu_outp                       FPU result, LATENCY edges after issue
//   res_valid/res_ready            result handshake
//   res_data, res_op               head result and the opcode that produced it
//   busy                           work queued, in flight, or pending
module fpu_issue #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [1:0]  in_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_opcode,
  input  logic [31:0] fpu_outp,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_op,
  output logic        busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Command FIFO storage, entry = {op, a, b}
  logic [65:0]        cmd_mem [DEPTH];
  logic [AW-1:0]      cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CW-1:0]      cmd_cnt_q, cmd_cnt_d;

  // Result FIFO storage, entry = {op, result}
  logic [33:0]        res_mem [DEPTH];
  logic [AW-1:0]      res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [CW-1:0]      res_cnt_q, res_cnt_d;

  // Credits in use: in-flight operations plus buffered results.
  logic [CW-1:0]      out_cnt_q, out_cnt_d;

  logic [LATENCY-1:0]      trk_vld_q, trk_vld_d;
  logic [LATENCY-1:0][1:0] trk_op_q, trk_op_d;

  logic [31:0]        fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic [1:0]         fpu_op_q, fpu_op_d;

  // Held low through reset so in_ready stays low until the first edge after release.
  logic               run_q;

  logic               push, issue, capture, pop;
  logic [65:0]        cmd_head;
  logic [33:0]        res_head;

  assign cmd_head  = cmd_mem[cmd_rd_q];
  assign res_head  = res_mem[res_rd_q];

  assign in_ready  = run_q && (cmd_cnt_q < FULL);
  assign push      = in_valid && in_ready;
  // Registered counts only: a pop this cycle frees its credit next cycle.
  assign issue     = (cmd_cnt_q != '0) && (out_cnt_q < FULL);
  assign capture   = trk_vld_q[LATENCY-1];
  assign res_valid = (res_cnt_q != '0);
  assign pop       = res_valid && res_ready;

  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_opcode = fpu_op_q;
  assign res_data   = res_valid ? res_head[31:0]  : 32'd0;
  assign res_op     = res_valid ? res_head[33:32] : 2'd0;
  assign busy       = (cmd_cnt_q != '0) || (out_cnt_q != '0);

  // Tracking pipe: stage 0 takes the issue, the last stage marks the capture edge.
  assign trk_vld_d[0] = issue;
  assign trk_op_d[0]  = cmd_head[65:64];
  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_trk
    assign trk_vld_d[gi] = trk_vld_q[gi-1];
    assign trk_op_d[gi]  = trk_op_q[gi-1];
  end

  always_comb begin
    cmd_wr_d  = cmd_wr_q;
    cmd_rd_d  = cmd_rd_q;
    res_wr_d  = res_wr_q;
    res_rd_d  = res_rd_q;
    fpu_a_d   = fpu_a_q;
    fpu_b_d   = fpu_b_q;
    fpu_op_d  = fpu_op_q;
    if (push)    cmd_wr_d = cmd_wr_q + 1'b1;
    if (issue) begin
      cmd_rd_d = cmd_rd_q + 1'b1;
      fpu_op_d = cmd_head[65:64];
      fpu_a_d  = cmd_head[63:32];
      fpu_b_d  = cmd_head[31:0];
    end
    if (capture) res_wr_d = res_wr_q + 1'b1;
    if (pop)     res_rd_d = res_rd_q + 1'b1;
    cmd_cnt_d = cmd_cnt_q + {{(CW-1){1'b0}}, push}    - {{(CW-1){1'b0}}, issue};
    res_cnt_d = res_cnt_q + {{(CW-1){1'b0}}, capture} - {{(CW-1){1'b0}}, pop};
    out_cnt_d = out_cnt_q + {{(CW-1){1'b0}}, issue}   - {{(CW-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
      out_cnt_q <= '0;
      trk_vld_q <= '0;
      trk_op_q  <= '0;
      fpu_a_q   <= '0;
      fpu_b_q   <= '0;
      fpu_op_q  <= '0;
    end else begin
      run_q     <= 1'b1;
      cmd_wr_q  <= cmd_wr_d;
      cmd_rd_q  <= cmd_rd_d;
      cmd_cnt_q <= cmd_cnt_d;
      res_wr_q  <= res_wr_d;
      res_rd_q  <= res_rd_d;
      res_cnt_q <= res_cnt_d;
      out_cnt_q <= out_cnt_d;
      trk_vld_q <= trk_vld_d;
      trk_op_q  <= trk_op_d;
      fpu_a_q   <= fpu_a_d;
      fpu_b_q   <= fpu_b_d;
      fpu_op_q  <= fpu_op_d;
    end
  end

  // Storage arrays carry no reset; occupancy is defined by the counts above.
  always_ff @(posedge clk) begin
    if (push)    cmd_mem[cmd_wr_q] <= {in_op, in_a, in_b};
    if (capture) res_mem[res_wr_q] <= {trk_op_q[LATENCY-1], fpu_outp};
  end

  // The credit rule guarantees room for every capture.
  always_ff @(posedge clk) begin
    if (rst_n && capture) assert (res_cnt_q != FULL);
  end
endmodule

// File: tb/tb_fpu_issue.sv
module tb_fpu_issue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] fpu_a, fpu_b, fpu_outp;
  logic [1:0]  fpu_opcode;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [1:0]  res_op;
  logic        busy;

  fpu_issue #(.DEPTH(4), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode),
    .fpu_outp(fpu_outp),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .busy(busy)
  );

  always #5 clk = ~clk;

  // FPU stub: integer sum of the operands, valid two edges after the operands
  // change; any other edge sees 0xDEADBEEF so a mistimed capture is visible.
  logic [65:0] stub_prev_q = '0;
  logic        stub_flag_q = 1'b0;
  logic [31:0] stub_sum_q  = 32'd0;
  always @(posedge clk) begin
    stub_prev_q <= {fpu_opcode, fpu_a, fpu_b};
    stub_flag_q <= ({fpu_opcode, fpu_a, fpu_b} != stub_prev_q);
    stub_sum_q  <= fpu_a + fpu_b;
  end
  assign fpu_outp = stub_flag_q ? stub_sum_q : 32'hDEADBEEF;

  // Reference model: results leave in acceptance order as {op, a+b}.
  logic [33:0] exp_q[$];
  int          acc_edges[$];
  int          pop_edges[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: decide handshakes from stable values, update the model, advance.
  task automatic tick(output logic acc);
    logic        pp;
    logic [33:0] e;
    acc = in_valid && in_ready;
    pp  = res_valid && res_ready;
    if (pp) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", {31'd0, res_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e[31:0]);
        chk("res_op", {30'd0, res_op}, {30'd0, e[33:32]});
        $display("cycle %0d: result data=%h op=%0d", cyc, res_data, res_op);
      end
      pop_edges.push_back(cyc);
    end
    if (acc) begin
      exp_q.push_back({in_op, in_a + in_b});
      acc_edges.push_back(cyc);
      $display("cycle %0d: accept a=%h b=%h op=%0d", cyc, in_a, in_b, in_op);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // New random command whose A operand differs from the previous one.
  task automatic gen_cmd();
    logic [31:0] a;
    a = $urandom;
    if (a == in_a) a = a + 32'd1;
    in_a  = a;
    in_b  = $urandom;
    in_op = 2'($urandom_range(0, 3));
  endtask

  task automatic push_n(input int n, input int budget);
    int   got;
    logic acc;
    got = 0;
    gen_cmd();
    in_valid = 1'b1;
    for (int i = 0; i < budget && got < n; i++) begin
      tick(acc);
      if (acc) begin
        got++;
        gen_cmd();
      end
    end
    in_valid = 1'b0;
    chk("push_count", 32'(got), 32'(n));
  endtask

  task automatic drain(input int budget);
    logic acc;
    res_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick(acc);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic acc;
    int   k;
    int   t0;

    // ---- reset values ----
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_fpu_op", {30'd0, fpu_opcode}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_op", {30'd0, res_op}, 32'd0);
    rst_n = 1'b1;
    chk("pre_edge_in_ready", {31'd0, in_ready}, 32'd0);
    tick(acc);
    chk("first_edge_in_ready", {31'd0, in_ready}, 32'd1);

    // ---- single operation, minimum latency ----
    res_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 2'd1;
    tick(acc);                           // edge t
    chk("single_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    chk("single_busy", {31'd0, busy}, 32'd1);
    tick(acc);                           // edge t+1: issue
    chk("issue_fpu_a", fpu_a, 32'h3F800000);
    chk("issue_fpu_b", fpu_b, 32'h40000000);
    chk("issue_fpu_op", {30'd0, fpu_opcode}, 32'd1);
    chk("lat_t1_res_valid", {31'd0, res_valid}, 32'd0);
    tick(acc);                           // edge t+2
    chk("lat_t2_res_valid", {31'd0, res_valid}, 32'd0);
    tick(acc);                           // edge t+3: captured
    chk("lat_t3_res_valid", {31'd0, res_valid}, 32'd1);
    chk("single_res_data", res_data, 32'h7F800000);
    chk("single_res_op", {30'd0, res_op}, 32'd1);
    tick(acc);                           // popped
    chk("single_done_valid", {31'd0, res_valid}, 32'd0);
    chk("single_done_busy", {31'd0, busy}, 32'd0);
    chk("single_fpu_hold", fpu_a, 32'h3F800000);

    // ---- back-pressure: 8 commands with res_ready low ----
    res_ready = 1'b0;
    push_n(8, 40);
    gen_cmd();
    in_valid = 1'b1;                     // ninth command must stay blocked
    for (int i = 0; i < 6; i++) tick(acc);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_total", 32'(exp_q.size()), 32'd8);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
    in_valid = 1'b0;
    drain(60);
    chk("bp_busy_end", {31'd0, busy}, 32'd0);

    // ---- streaming: 16 back-to-back commands ----
    acc_edges.delete();
    pop_edges.delete();
    res_ready = 1'b1;
    in_valid = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 16; i++) begin
      in_a = 32'(k); in_b = 32'h100; in_op = 2'(k);
      tick(acc);
      if (acc) k++;
    end
    in_valid = 1'b0;
    drain(40);
    chk("stream_results", 32'(pop_edges.size()), 32'd16);
    if (acc_edges.size() > 0) begin
      t0 = acc_edges[0];
      for (int i = 0; i < pop_edges.size(); i++)
        chk("stream_pop_edge", 32'(pop_edges[i]), 32'(t0 + 4 + i));
    end

    // ---- simultaneous pop and capture with three results buffered ----
    res_ready = 1'b0;
    push_n(3, 10);
    for (int i = 0; i < 5; i++) tick(acc);
    gen_cmd();
    in_valid = 1'b1;
    tick(acc);                           // edge a
    chk("sim_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    tick(acc);
    tick(acc);
    res_ready = 1'b1;
    tick(acc);                           // edge a+3: pop and capture together
    res_ready = 1'b0;
    chk("sim_res_valid", {31'd0, res_valid}, 32'd1);
    chk("sim_pending", 32'(exp_q.size()), 32'd3);
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick(acc);
    chk("sim_empty_valid", {31'd0, res_valid}, 32'd0);
    chk("sim_empty_model", 32'(exp_q.size()), 32'd0);

    // ---- reset mid-operation ----
    res_ready = 1'b0;
    gen_cmd();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      if (acc) gen_cmd();
    end
    in_valid = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_fpu_a", fpu_a, 32'd0);
    chk("mid_rst_fpu_b", fpu_b, 32'd0);
    chk("mid_rst_fpu_op", {30'd0, fpu_opcode}, 32'd0);
    chk("mid_rst_res_data", res_data, 32'd0);
    chk("mid_rst_res_op", {30'd0, res_op}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(acc);
      chk("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ---- operation resumes cleanly ----
    push_n(2, 10);
    drain(20);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
